eth_irq_coalesce: RTL
=====================

ETH_IRQ_COALESCE -- requirements
Module: eth_irq_coalesce

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4, number of Ethernet channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, event counter and threshold width.
REQ-003 SHALL have parameter TMR_W, default 16, coalescing timer and timeout width.
REQ-004 SHALL have ports: clock  input  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports: async_reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports: irq_event  input  N_CHANNELS  per-channel single-cycle event pulse (packet done).
REQ-007 SHALL have ports: irq_ack  input  N_CHANNELS  per-channel write-one-to-clear pulse.
REQ-008 SHALL have ports: cfg_enable  input  N_CHANNELS  per-channel enable.
REQ-009 SHALL have ports: cfg_count_thresh  input  CNT_W  events needed to fire, shared by all channels.
REQ-010 SHALL have ports: cfg_timeout  input  TMR_W  cycles from first event to forced fire, shared.
REQ-011 SHALL have ports: pending  output  N_CHANNELS  per-channel fired-and-unacknowledged flag.
REQ-012 SHALL have ports: fire_count  output  N_CHANNELS*CNT_W  per-channel events latched at fire, channel i at [i*CNT_W +: CNT_W].
REQ-013 SHALL have ports: interrupt  output  1  registered OR of pending, level-high.

Function
REQ-014 Each channel SHALL run its own FSM with states IDLE, ACCUM, FIRE.
REQ-015 IDLE: event -> ACCUM, count=1, timer=0; no event -> stay.
REQ-016 ACCUM: each event increments count, saturating at 2^CNT_W-1; timer increments each cycle, saturating.
REQ-017 ACCUM -> FIRE when count (including this cycle's event) >= effective threshold, or cfg_timeout!=0 and timer+1 == cfg_timeout.
REQ-018 Effective threshold SHALL be max(cfg_count_thresh,1); threshold 1 fires the cycle after the first event.
REQ-019 On entering FIRE: pending<=1, fire_count<=count, missed<=0; latency event-to-pending SHALL be 1 cycle when threshold reached.
REQ-020 FIRE: events increment missed (saturating); further threshold or timeout conditions SHALL NOT alter fire_count.
REQ-021 FIRE + ack: pending<=0; if missed+event>0 -> ACCUM with count=missed+event, timer=0; else -> IDLE.
REQ-022 Ack in IDLE or ACCUM SHALL be ignored.
REQ-023 cfg_enable low SHALL force IDLE next cycle, clear count, timer, missed, pending; fire_count holds; events ignored.
REQ-024 Config changes mid-ACCUM SHALL take effect the next cycle compare; no retroactive fire.
REQ-025 interrupt SHALL be registered: interrupt(t+1) = |pending(t); one cycle after pending.

Reset
REQ-026 async_reset SHALL immediately force all channels to IDLE, counts/timers/missed to 0, pending 0, fire_count 0, interrupt 0.
REQ-027 Reset deassertion SHALL be synchronised to clock by a 2-flop synchroniser inside the block; reset mid-FIRE discards the pending interrupt.

Structure
REQ-028 Shared package eth_irq_pkg SHALL hold the state typedef (IDLE, ACCUM, FIRE) and default CNT_W/TMR_W constants.
REQ-029 Per-channel logic SHALL be sub-module eth_irq_coalesce_chan, instantiated N_CHANNELS times via generate; top holds OR and interrupt register.

Verification
REQ-030 Thresh=4, timeout=0, ch0 4 events on consecutive cycles -> pending[0]=1 cycle after 4th, fire_count[0]=4, interrupt one cycle later.
REQ-031 Thresh=10, timeout=20, ch1 single event at t0 -> pending[1] rises at t0+20, fire_count[1]=1.
REQ-032 Ch2 in FIRE, 3 events, then ack with simultaneous event -> pending clears, ACCUM count=4, refire per threshold.
REQ-033 CNT_W=8, thresh=0 vs 255: thresh 0 fires after 1 event; 300 events during FIRE -> missed saturates at 255.
REQ-034 N_CHANNELS=4, all channels fire, ack one by one -> interrupt stays high until last ack, low 1 cycle after.
REQ-035 Async reset asserted mid-ACCUM and mid-FIRE (off clock edge) -> all outputs 0 immediately; cfg_enable drop -> IDLE, pending 0 next cycle.

Source files
------------

// File: rtl/eth_irq_pkg.sv
// Shared types and default widths for the Ethernet interrupt coalescer.
// Per-channel FSM encoding is exposed on dbg_state so checkers can bind to it.
package eth_irq_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int TMR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/eth_irq_coalesce_chan.sv
// One coalescing channel: counts event pulses and fires on threshold or timeout.
// irq_event and irq_ack are single-cycle pulses sampled on every rising clock edge.
module eth_irq_coalesce_chan
  import eth_irq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMR_W = TMR_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              irq_event,
  input  logic              irq_ack,
  input  logic              cfg_enable,
  input  logic [CNT_W-1:0]  cfg_count_thresh,
  input  logic [TMR_W-1:0]  cfg_timeout,
  output logic              pending,
  output logic [CNT_W-1:0]  fire_count,
  output chan_state_e       state
);

  chan_state_e      state_d;
  logic [CNT_W-1:0] count, count_d, count_inc;
  logic [TMR_W-1:0] timer, timer_d, timer_inc;
  logic [CNT_W-1:0] missed, missed_d, missed_inc;
  logic             pending_d;
  logic [CNT_W-1:0] fire_count_d;
  logic [CNT_W-1:0] eff_thresh;
  logic [TMR_W:0]   timer_p1;
  logic             thresh_hit, timeout_hit;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      timer      <= '0;
      missed     <= '0;
      pending    <= 1'b0;
      fire_count <= '0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      timer      <= timer_d;
      missed     <= missed_d;
      pending    <= pending_d;
      fire_count <= fire_count_d;
    end
  end

  always_comb begin
    state_d      = state;
    count_d      = count;
    timer_d      = timer;
    missed_d     = missed;
    pending_d    = pending;
    fire_count_d = fire_count;

    // Saturating increments; the compare uses a widened timer so timer+1 never wraps.
    count_inc   = (irq_event && !(&count))  ? count + 1'b1  : count;
    missed_inc  = (irq_event && !(&missed)) ? missed + 1'b1 : missed;
    timer_inc   = (&timer) ? timer : timer + 1'b1;
    timer_p1    = {1'b0, timer} + {{TMR_W{1'b0}}, 1'b1};
    eff_thresh  = (cfg_count_thresh == '0) ? CNT_W'(1) : cfg_count_thresh;
    thresh_hit  = (count_inc >= eff_thresh);
    timeout_hit = (cfg_timeout != '0) && (timer_p1 == {1'b0, cfg_timeout});

    if (!cfg_enable) begin
      state_d   = IDLE;
      count_d   = '0;
      timer_d   = '0;
      missed_d  = '0;
      pending_d = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (irq_event) begin
            state_d = ACCUM;
            count_d = CNT_W'(1);
            timer_d = '0;
          end
        end
        ACCUM: begin
          if (thresh_hit || timeout_hit) begin
            state_d      = FIRE;
            pending_d    = 1'b1;
            fire_count_d = count_inc;
            missed_d     = '0;
          end else begin
            count_d = count_inc;
            timer_d = timer_inc;
          end
        end
        FIRE: begin
          missed_d = missed_inc;
          if (irq_ack) begin
            pending_d = 1'b0;
            missed_d  = '0;
            timer_d   = '0;
            // Events that arrived while fired seed the next accumulation window.
            if (missed_inc != '0) begin
              state_d = ACCUM;
              count_d = missed_inc;
            end else begin
              state_d = IDLE;
              count_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/eth_irq_coalesce.sv
// Top of the interrupt coalescer: reset synchroniser, per-channel FSMs and
// the registered interrupt line (one cycle behind the OR of pending).
module eth_irq_coalesce
  import eth_irq_pkg::*;
#(
  parameter int N_CHANNELS = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TMR_W      = TMR_W_DEF
) (
  input  logic                        clock,
  input  logic                        async_reset,
  input  logic [N_CHANNELS-1:0]       irq_event,
  input  logic [N_CHANNELS-1:0]       irq_ack,
  input  logic [N_CHANNELS-1:0]       cfg_enable,
  input  logic [CNT_W-1:0]            cfg_count_thresh,
  input  logic [TMR_W-1:0]            cfg_timeout,
  output logic [N_CHANNELS-1:0]       pending,
  output logic [N_CHANNELS*CNT_W-1:0] fire_count,
  output logic                        interrupt,
  output logic [2*N_CHANNELS-1:0]     dbg_state
);

  logic [1:0] rst_sync;
  logic       rst;

  // Assertion propagates asynchronously; release waits two clock edges.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) rst_sync <= 2'b11;
    else             rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
    chan_state_e chan_state;

    eth_irq_coalesce_chan #(
      .CNT_W (CNT_W),
      .TMR_W (TMR_W)
    ) u_chan (
      .clock            (clock),
      .rst              (rst),
      .irq_event        (irq_event[i]),
      .irq_ack          (irq_ack[i]),
      .cfg_enable       (cfg_enable[i]),
      .cfg_count_thresh (cfg_count_thresh),
      .cfg_timeout      (cfg_timeout),
      .pending          (pending[i]),
      .fire_count       (fire_count[i*CNT_W +: CNT_W]),
      .state            (chan_state)
    );

    assign dbg_state[2*i +: 2] = chan_state;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) interrupt <= 1'b0;
    else     interrupt <= |pending;
  end

endmodule
